// File: rtl/tw4_irq_pkg.sv
// Shared types and helpers for the TW4 interrupt controller.
//   irq_state_e  : acknowledge FSM states (IDLE, VEC)
//   lowest_t     : result of lowest_set() -> {found, idx}
//   lowest_set() : index of the lowest set bit of a 16-bit vector
//   below_mask() : bits strictly below the lowest set bit (all ones when empty)
// Helpers work on 16 bits, the largest supported source count; callers
// zero-extend narrower vectors.
package tw4_irq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        VEC  = 1'b1
    } irq_state_e;

    localparam int N_SRC_DEF = 8;
    localparam int VEC_W_DEF = 8;
    localparam int MAX_SRC   = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } lowest_t;

    function automatic lowest_t lowest_set(input logic [MAX_SRC-1:0] v);
        lowest_t r;
        r.found = 1'b0;
        r.idx   = '0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_SRC-1:0] below_mask(input logic [MAX_SRC-1:0] v);
        logic [MAX_SRC-1:0] r;
        if (v == '0) begin
            r = '1;
        end else begin
            // Isolate the lowest set bit, then subtract one to get everything below it.
            r = (v & (~v + 16'd1)) - 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for a bus of level signals.
//   clock, reset_n : clock and asynchronous active-low reset
//   level_i        : levels to watch
//   rise_o         : one-cycle pulse per bit on a 0->1 transition
// The previous-value register resets to all ones, so a level that is already
// high when reset is released does not produce an edge.
module irq_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller (one daisy-chain member) for the TW4 CPU.
//   clock, reset_n  : clock, asynchronous active-low reset
//   src_in, src_ie  : source levels (rising edge requests), per-source enables
//   vec_base        : vector base; low IDX_W+1 bits ignored
//   inta, reti      : CPU acknowledge / return levels, acted on at their rising edge
//   iei, ieo        : daisy-chain enable in / out
//   irq             : request to the CPU
//   vector,
//   vector_valid    : {vec_base high bits, winner index, 0}, strobed for one cycle
//   pending,
//   in_service      : status
//   state_dbg_o     : acknowledge FSM state (0 = IDLE, 1 = VEC)
// Handshake: the CPU raises inta while irq is high; the cycle after that edge
// is sampled, vector_valid is high for exactly one cycle and vector holds the
// winner. An inta edge seen while irq is low is ignored (no strobe). Lowest
// index wins; a source may only win when its index is below every in-service
// source, which gives nesting. reti clears the lowest in-service bit.
module irq_controller
    import tw4_irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int VEC_W = VEC_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src_in,
    input  logic [N_SRC-1:0] src_ie,
    input  logic [VEC_W-1:0] vec_base,
    input  logic             inta,
    input  logic             reti,
    input  logic             iei,
    output logic             ieo,
    output logic             irq,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service,
    output logic             state_dbg_o
);

    localparam int IDX_W = $clog2(N_SRC);

    irq_state_e         state_q;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   in_service_q, in_service_d;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic               vector_valid_q;

    logic [N_SRC-1:0]   src_rise;
    logic               inta_e, reti_e;

    logic [MAX_SRC-1:0] pend_ext, insvc_ext, mask_ext, elig_ext;
    lowest_t            win;
    logic [N_SRC-1:0]   win_oh;
    logic               accept;
    logic               unused_bits;

    irq_edge_detect #(.WIDTH(N_SRC)) u_src_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level_i (src_in),
        .rise_o  (src_rise)
    );

    irq_edge_detect #(.WIDTH(1)) u_inta_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level_i (inta),
        .rise_o  (inta_e)
    );

    irq_edge_detect #(.WIDTH(1)) u_reti_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level_i (reti),
        .rise_o  (reti_e)
    );

    always_comb begin
        pend_ext                = '0;
        insvc_ext               = '0;
        pend_ext[N_SRC-1:0]     = pending_q;
        insvc_ext[N_SRC-1:0]    = in_service_q;
    end

    assign mask_ext = below_mask(insvc_ext);
    assign elig_ext = pend_ext & mask_ext;
    assign win      = lowest_set(elig_ext);
    assign win_oh   = N_SRC'(1) << win.idx;

    assign irq    = iei & win.found & (state_q == IDLE);
    assign ieo    = iei & ~win.found & ~|in_service_q;
    assign accept = inta_e & irq;

    assign vector_d = {vec_base[VEC_W-1:IDX_W+1], win.idx[IDX_W-1:0], 1'b0};

    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        if (reti_e) begin
            in_service_d = in_service_q & (in_service_q - N_SRC'(1));
        end
        // The winner always sits below the lowest in-service bit, so it never
        // collides with the bit reti clears.
        if (accept) begin
            pending_d    = pending_d & ~win_oh;
            in_service_d = in_service_d | win_oh;
        end
        // Applied last so a new edge beats the acknowledge clear.
        pending_d = pending_d | (src_rise & src_ie);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            in_service_q   <= '0;
            vector_q       <= '0;
            vector_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q        <= VEC;
                        vector_q       <= vector_d;
                        vector_valid_q <= 1'b1;
                    end else begin
                        vector_valid_q <= 1'b0;
                    end
                end
                VEC: begin
                    state_q        <= IDLE;
                    vector_valid_q <= 1'b0;
                end
                default: begin
                    state_q        <= IDLE;
                    vector_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign vector       = vector_q;
    assign vector_valid = vector_valid_q;
    assign pending      = pending_q;
    assign in_service   = in_service_q;
    assign state_dbg_o  = state_q;

    assign unused_bits = ^{vec_base[IDX_W:0], win.idx};

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    logic       clock;
    logic       reset_n;
    logic [7:0] src_in;
    logic [7:0] src_ie;
    logic [7:0] vec_base;
    logic       inta;
    logic       reti;
    logic       iei;
    logic       ieo;
    logic       irq;
    logic [7:0] vector;
    logic       vector_valid;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic       state_dbg_o;

    int n_vec;
    int n_err;

    irq_controller #(.N_SRC(8), .VEC_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .src_in       (src_in),
        .src_ie       (src_ie),
        .vec_base     (vec_base),
        .inta         (inta),
        .reti         (reti),
        .iei          (iei),
        .ieo          (ieo),
        .irq          (irq),
        .vector       (vector),
        .vector_valid (vector_valid),
        .pending      (pending),
        .in_service   (in_service),
        .state_dbg_o  (state_dbg_o)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Per-source bit arrays; priority, masking and nesting are evaluated by
    // scanning source indices, straight from the behavioural rules.
    bit [7:0] m_pend;
    bit [7:0] m_insvc;
    bit [7:0] m_prev_src;
    bit       m_prev_inta;
    bit       m_prev_reti;
    bit       m_in_vec;
    bit       m_valid;
    bit [7:0] m_vector;

    task automatic model_reset();
        m_pend      = '0;
        m_insvc     = '0;
        m_prev_src  = 8'hFF;
        m_prev_inta = 1'b1;
        m_prev_reti = 1'b1;
        m_in_vec    = 1'b0;
        m_valid     = 1'b0;
        m_vector    = '0;
    endtask

    task automatic model_eval(output bit e_irq, output bit e_ieo, output int e_win);
        int lowest_isr;
        lowest_isr = 8;
        for (int i = 7; i >= 0; i--) if (m_insvc[i]) lowest_isr = i;
        e_win = -1;
        for (int i = 0; i < lowest_isr; i++) if (m_pend[i] && e_win < 0) e_win = i;
        e_irq = iei && (e_win >= 0) && !m_in_vec;
        e_ieo = iei && (e_win < 0) && (m_insvc == 8'h00);
    endtask

    task automatic model_step();
        bit e_irq, e_ieo, inta_rise, reti_rise, ack, done;
        int e_win;
        model_eval(e_irq, e_ieo, e_win);
        inta_rise = inta && !m_prev_inta;
        reti_rise = reti && !m_prev_reti;
        ack       = inta_rise && e_irq;
        if (reti_rise) begin
            done = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (m_insvc[i] && !done) begin
                    m_insvc[i] = 1'b0;
                    done       = 1'b1;
                end
            end
        end
        if (ack) begin
            m_pend[e_win]  = 1'b0;
            m_insvc[e_win] = 1'b1;
            m_vector       = (vec_base & 8'hF0) + 8'(e_win * 2);
        end
        for (int i = 0; i < 8; i++) begin
            if (src_in[i] && !m_prev_src[i] && src_ie[i]) m_pend[i] = 1'b1;
        end
        m_in_vec    = ack;
        m_valid     = ack;
        m_prev_src  = src_in;
        m_prev_inta = inta;
        m_prev_reti = reti;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit e_irq, e_ieo;
        int e_win;
        model_eval(e_irq, e_ieo, e_win);
        check_eq("irq", 32'(irq), 32'(e_irq));
        check_eq("ieo", 32'(ieo), 32'(e_ieo));
        check_eq("pending", 32'(pending), 32'(m_pend));
        check_eq("in_service", 32'(in_service), 32'(m_insvc));
        check_eq("vector", 32'(vector), 32'(m_vector));
        check_eq("vector_valid", 32'(vector_valid), 32'(m_valid));
        check_eq("state", 32'(state_dbg_o), 32'(m_in_vec));
    endtask

    // One clock: check settled outputs, advance model on the edge, land 1 ns after it.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clock);
        if (!reset_n) model_reset();
        else          model_step();
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_src(input logic [7:0] bits);
        src_in = bits;
        tick(1);
        src_in = 8'h00;
    endtask

    task automatic do_ack();
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        tick(1);
    endtask

    task automatic apply_reset(input int hold);
        reset_n = 1'b0;
        model_reset();
        tick(hold);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b1;
        src_in   = 8'h00;
        src_ie   = 8'hFF;
        vec_base = 8'hA0;
        inta     = 1'b0;
        reti     = 1'b0;
        iei      = 1'b1;
        model_reset();
        #2;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        tick(2);
        reset_n = 1'b1;
        check_eq("reset_pending", 32'(pending), 32'h00);
        check_eq("reset_vector", 32'(vector), 32'h00);
        tick(2);

        // 1: single source
        pulse_src(8'h04);
        check_eq("s1_pending", 32'(pending), 32'h04);
        check_eq("s1_irq", 32'(irq), 32'h1);
        do_ack();
        check_eq("s1_vector", 32'(vector), 32'hA4);
        check_eq("s1_valid", 32'(vector_valid), 32'h1);
        check_eq("s1_insvc", 32'(in_service), 32'h04);
        check_eq("s1_irq_low", 32'(irq), 32'h0);
        check_eq("s1_ieo_low", 32'(ieo), 32'h0);
        tick(1);
        check_eq("s1_valid_drop", 32'(vector_valid), 32'h0);
        do_reti();

        // 2: two at once, masked second ack
        pulse_src(8'h22);
        do_ack();
        check_eq("s2_vector1", 32'(vector), 32'hA2);
        tick(1);
        do_ack();
        check_eq("s2_no_strobe", 32'(vector_valid), 32'h0);
        check_eq("s2_pending", 32'(pending), 32'h20);
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        check_eq("s2_insvc_clr", 32'(in_service), 32'h00);
        check_eq("s2_irq_back", 32'(irq), 32'h1);
        do_ack();
        check_eq("s2_vector2", 32'(vector), 32'hAA);
        tick(1);
        do_reti();

        // 3: nesting
        pulse_src(8'h10);
        do_ack();
        tick(1);
        pulse_src(8'h01);
        do_ack();
        check_eq("s3_vector", 32'(vector), 32'hA0);
        check_eq("s3_insvc", 32'(in_service), 32'h11);
        tick(1);
        do_reti();
        check_eq("s3_reti1", 32'(in_service), 32'h10);
        do_reti();
        check_eq("s3_reti2", 32'(in_service), 32'h00);

        // 4: daisy chain blocked
        pulse_src(8'h08);
        iei = 1'b0;
        tick(1);
        check_eq("s4_irq_blk", 32'(irq), 32'h0);
        check_eq("s4_ieo_blk", 32'(ieo), 32'h0);
        do_ack();
        check_eq("s4_pending", 32'(pending), 32'h08);
        check_eq("s4_no_strobe", 32'(vector_valid), 32'h0);
        iei = 1'b1;
        tick(1);
        check_eq("s4_irq_open", 32'(irq), 32'h1);
        do_ack();
        tick(1);
        do_reti();

        // 5: levels through reset, disabled source, set/clear collision
        src_in = 8'hFF;
        apply_reset(2);
        tick(2);
        check_eq("s5_no_pend", 32'(pending), 32'h00);
        src_in = 8'h00;
        tick(1);
        src_ie = 8'hF7;
        pulse_src(8'h08);
        check_eq("s5_ie_gate", 32'(pending), 32'h00);
        src_ie = 8'hFF;
        tick(1);
        pulse_src(8'h40);
        tick(1);
        inta   = 1'b1;
        src_in = 8'h40;
        tick(1);
        inta   = 1'b0;
        src_in = 8'h00;
        check_eq("s5_collide_pend", 32'(pending), 32'h40);
        check_eq("s5_collide_isr", 32'(in_service), 32'h40);
        tick(1);
        do_reti();
        do_ack();
        tick(1);
        do_reti();

        // 6: reset during the VEC cycle
        pulse_src(8'h02);
        do_ack();
        check_eq("s6_in_vec", 32'(vector_valid), 32'h1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("s6_rst_valid", 32'(vector_valid), 32'h0);
        check_eq("s6_rst_vector", 32'(vector), 32'h00);
        check_eq("s6_rst_insvc", 32'(in_service), 32'h00);
        check_eq("s6_rst_irq", 32'(irq), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check_eq("s6_no_strobe", 32'(vector_valid), 32'h0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) src_in = 8'($urandom);
            if ($urandom_range(0, 49) == 0) src_ie = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 99) == 0) vec_base = 8'($urandom);
            inta = ($urandom_range(0, 4) == 0);
            reti = ($urandom_range(0, 6) == 0);
            iei  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) begin
                apply_reset($urandom_range(1, 3));
            end else begin
                tick(1);
            end
        end
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
